logic_unit_pipe: RTL and testbench

//  Parametrised, pipelined successor to the 64-bit combinational logic unit.

---
 rtl/logic_unit_pkg.sv | 22 ++
 rtl/logic_unit_core.sv | 36 +++
 rtl/logic_unit_pipe.sv | 117 +++++++++++
 tb/tb_logic_unit_pipe.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined logic unit.
// Op encodings and the result flag bundle.
package logic_unit_pkg;

    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] OP_AND  = 3'd0;
    localparam logic [SEL_W-1:0] OP_NAND = 3'd1;
    localparam logic [SEL_W-1:0] OP_OR   = 3'd2;
    localparam logic [SEL_W-1:0] OP_NOR  = 3'd3;
    localparam logic [SEL_W-1:0] OP_XOR  = 3'd4;
    localparam logic [SEL_W-1:0] OP_XNOR = 3'd5;
    localparam logic [SEL_W-1:0] OP_NOTA = 3'd6;
    localparam logic [SEL_W-1:0] OP_NOTB = 3'd7;

    typedef struct packed {
        logic zero;
        logic ones;
        logic parity;
    } flags_t;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise op and result flags.
// Sits between the operand stage and the result stage.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] res,
    output flags_t           flags
);

    always_comb begin
        res = '0;
        unique case (sel)
            OP_AND:  res = op_a & op_b;
            OP_NAND: res = ~(op_a & op_b);
            OP_OR:   res = op_a | op_b;
            OP_NOR:  res = ~(op_a | op_b);
            OP_XOR:  res = op_a ^ op_b;
            OP_XNOR: res = ~(op_a ^ op_b);
            OP_NOTA: res = ~op_a;
            OP_NOTB: res = ~op_b;
        endcase
    end

    always_comb begin
        flags        = '0;
        flags.zero   = ~|res;
        flags.ones   = &res;
        flags.parity = ^res;
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined logic unit with valid/ready handshake,
// accumulate mode and a completed-result counter.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_0,
    input  logic [WIDTH-1:0] in_1,
    input  logic [SEL_W-1:0] sel,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             ones,
    output logic             parity,
    output logic [CNT_W-1:0] result_count
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [SEL_W-1:0] s1_sel;
    logic             s1_acc_en;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] res;
    flags_t           flags;

    logic s2_adv;
    logic s1_adv;
    logic s12_xfer;
    logic out_xfer;

    // Ready chains backwards through both stages without a register loop.
    assign s2_adv   = !out_valid | out_ready;
    assign s1_adv   = !s1_valid | s2_adv;
    assign in_ready = s1_adv;
    assign s12_xfer = s1_valid & s2_adv;
    assign out_xfer = out_valid & out_ready;

    assign op_a = s1_acc_en ? acc : s1_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_sel    <= OP_AND;
            s1_acc_en <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a      <= in_0;
                s1_b      <= in_1;
                s1_sel    <= sel;
                s1_acc_en <= acc_en;
            end
        end
    end

    logic_unit_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op_a  (op_a),
        .op_b  (s1_b),
        .sel   (s1_sel),
        .res   (res),
        .flags (flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            zero      <= 1'b1;
            ones      <= 1'b0;
            parity    <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out    <= res;
                zero   <= flags.zero;
                ones   <= flags.ones;
                parity <= flags.parity;
            end
        end
    end

    // A clear coincident with a transfer wins; that beat already used old acc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (acc_clr) begin
            acc <= '0;
        end else if (s12_xfer) begin
            acc <= res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_count <= '0;
        end else if (out_xfer) begin
            result_count <= result_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench: vector table, directed corner cases and
// randomized traffic against a queue-based reference model.
module tb_logic_unit_pipe;
    import logic_unit_pkg::*;

    localparam int W = 64;

    typedef struct packed {
        logic [W-1:0] o;
        logic         z;
        logic         on;
        logic         p;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   s;
        logic [W-1:0] o;
        logic         z;
        logic         on;
        logic         p;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid, in_ready;
    logic [W-1:0] in_0, in_1;
    logic [2:0]   sel;
    logic         acc_en, acc_clr;
    logic         out_valid, out_ready;
    logic [W-1:0] out;
    logic         zero, ones, parity;
    logic [15:0]  result_count;

    logic         b_in_valid, b_in_ready;
    logic [7:0]   b_in_0, b_in_1;
    logic [2:0]   b_sel;
    logic         b_acc_en, b_acc_clr;
    logic         b_out_valid, b_out_ready;
    logic [7:0]   b_out;
    logic         b_zero, b_ones, b_parity;
    logic [3:0]   b_count;

    logic_unit_pipe #(.WIDTH(64), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_0(in_0), .in_1(in_1), .sel(sel),
        .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .zero(zero), .ones(ones), .parity(parity),
        .result_count(result_count)
    );

    logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_0(b_in_0), .in_1(b_in_1), .sel(b_sel),
        .acc_en(b_acc_en), .acc_clr(b_acc_clr),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out(b_out), .zero(b_zero), .ones(b_ones), .parity(b_parity),
        .result_count(b_count)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;
    res_t exp_q[$];
    logic [W-1:0] last_res = '0;

    // out_ready source: 0 always, 1 never, 2 toggling, 3 random
    int   bp_mode = 0;
    logic tog = 1'b0;
    logic rnd = 1'b1;
    assign out_ready = (bp_mode == 0) ? 1'b1 :
                       (bp_mode == 1) ? 1'b0 :
                       (bp_mode == 2) ? tog : rnd;

    always @(posedge clk) begin
        #1;
        tog = ~tog;
        rnd = 1'($urandom);
    end

    function automatic logic [W-1:0] ref_op(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic [2:0] s);
        case (s)
            3'd0: return a & b;
            3'd1: return ~(a & b);
            3'd2: return a | b;
            3'd3: return ~(a | b);
            3'd4: return a ^ b;
            3'd5: return ~(a ^ b);
            3'd6: return ~a;
            default: return ~b;
        endcase
    endfunction

    function automatic res_t mk(input logic [W-1:0] r);
        res_t t;
        t.o  = r;
        t.z  = (r == '0);
        t.on = (r == '1);
        t.p  = ^r;
        return t;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard: in-order results and AXI-style hold while stalled.
    logic prev_stall = 1'b0;
    res_t prev_r;
    always @(negedge clk) begin
        res_t cur, e;
        cur.o  = out;
        cur.z  = zero;
        cur.on = ones;
        cur.p  = parity;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_cmp++;
                if (!out_valid || cur !== prev_r) begin
                    n_bad++;
                    $display("FAIL hold: got v=%b %h want v=1 %h",
                             out_valid, cur, prev_r);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_out: got %h want none", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        n_bad++;
                        $display("FAIL result: got %h want %h", cur, e);
                    end
                end
                n_out++;
            end
            prev_stall = out_valid && !out_ready;
            prev_r = cur;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] s, input logic ae,
                        input logic ac, input res_t e);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_0 = a;
        in_1 = b;
        sel = s;
        acc_en = ae;
        acc_clr = ac;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready=0 want 1");
        end else begin
            exp_q.push_back(e);
            last_res = e.o;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc_clr = 1'b0;
    endtask

    task automatic rnd_send(input logic allow_acc);
        logic [W-1:0] a, b, aa;
        logic [2:0] s;
        logic ae;
        a  = {$urandom, $urandom};
        b  = {$urandom, $urandom};
        s  = 3'($urandom);
        ae = allow_acc ? 1'($urandom) : 1'b0;
        aa = ae ? last_res : a;
        send(a, b, s, ae, 1'b0, mk(ref_op(aa, b, s)));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
    endtask

    vec_t tv[11];

    initial begin
        logic [W-1:0] va, vb, ea;
        res_t e3;
        va = 64'hF0F0_F0F0_F0F0_F0F0;
        vb = 64'hFF00_FF00_FF00_FF00;
        tv[0]  = '{va, vb, 3'd0, 64'hF000_F000_F000_F000, 0, 0, 0};
        tv[1]  = '{va, vb, 3'd1, 64'h0FFF_0FFF_0FFF_0FFF, 0, 0, 0};
        tv[2]  = '{va, vb, 3'd2, 64'hFFF0_FFF0_FFF0_FFF0, 0, 0, 0};
        tv[3]  = '{va, vb, 3'd3, 64'h000F_000F_000F_000F, 0, 0, 0};
        tv[4]  = '{va, vb, 3'd4, 64'h0FF0_0FF0_0FF0_0FF0, 0, 0, 0};
        tv[5]  = '{va, vb, 3'd5, 64'hF00F_F00F_F00F_F00F, 0, 0, 0};
        tv[6]  = '{va, vb, 3'd6, 64'h0F0F_0F0F_0F0F_0F0F, 0, 0, 0};
        tv[7]  = '{va, vb, 3'd7, 64'h00FF_00FF_00FF_00FF, 0, 0, 0};
        tv[8]  = '{64'd0, 64'd0, 3'd2, 64'd0, 1, 0, 0};
        tv[9]  = '{64'd0, 64'd0, 3'd3, '1, 0, 1, 0};
        tv[10] = '{64'd1, 64'd0, 3'd4, 64'd1, 0, 0, 1};

        rst_n = 1'b0;
        in_valid = 0; in_0 = '0; in_1 = '0; sel = '0;
        acc_en = 0; acc_clr = 0;
        b_in_valid = 0; b_in_0 = '0; b_in_1 = '0; b_sel = '0;
        b_acc_en = 0; b_acc_clr = 0; b_out_ready = 1'b1;

        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_zero", 64'(zero), 64'd1);
        chk("rst_ones", 64'(ones), 64'd0);
        chk("rst_parity", 64'(parity), 64'd0);
        chk("rst_out", out, 64'd0);
        chk("rst_count", 64'(result_count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_b_zero", 64'(b_zero), 64'd1);
        chk("rst_b_count", 64'(b_count), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Op sweep with latency check
        for (int i = 0; i < 11; i++) begin
            res_t t;
            t.o = tv[i].o; t.z = tv[i].z; t.on = tv[i].on; t.p = tv[i].p;
            send(tv[i].a, tv[i].b, tv[i].s, 1'b0, 1'b0, t);
            @(negedge clk);
            chk($sformatf("lat1_%0d", i), 64'(out_valid), 64'd0);
            @(negedge clk);
            chk($sformatf("lat2_%0d", i), 64'(out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        drain();

        // Backpressure with toggling out_ready
        bp_mode = 2;
        for (int i = 0; i < 8; i++) rnd_send(1'b1);
        drain();

        // Both stages full, out_ready low: in_ready must drop
        bp_mode = 1;
        rnd_send(1'b0);
        rnd_send(1'b0);
        ea = {$urandom, $urandom};
        e3 = mk(ref_op(last_res, ea, 3'd4));
        in_valid = 1'b1; in_0 = {$urandom, $urandom}; in_1 = ea;
        sel = 3'd4; acc_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("full_in_ready", 64'(in_ready), 64'd0);
            chk("full_out_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        bp_mode = 0;
        @(negedge clk);
        chk("release_in_ready", 64'(in_ready), 64'd1);
        exp_q.push_back(e3);
        last_res = e3.o;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Accumulate chain, then clear coincident with a transfer
        acc_clr = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        send({$urandom, $urandom}, 64'd1, 3'd2, 1'b1, 1'b0, mk(64'd1));
        send({$urandom, $urandom}, 64'd2, 3'd2, 1'b1, 1'b0, mk(64'd3));
        send({$urandom, $urandom}, 64'd4, 3'd2, 1'b1, 1'b0, mk(64'd7));
        send({$urandom, $urandom}, 64'd8, 3'd2, 1'b1, 1'b0, mk(64'd15));
        send({$urandom, $urandom}, 64'd16, 3'd2, 1'b1, 1'b0, mk(64'd31));
        send({$urandom, $urandom}, 64'd32, 3'd2, 1'b1, 1'b1, mk(64'd32));
        send({$urandom, $urandom}, 64'd0, 3'd2, 1'b1, 1'b0, mk(64'd32));
        drain();

        // Randomized traffic with random backpressure
        bp_mode = 3;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            rnd_send(1'b1);
        end
        bp_mode = 0;
        drain();
        chk("count", 64'(result_count), 64'(n_out[15:0]));

        // Reset mid-stream discards in-flight beats
        bp_mode = 1;
        rnd_send(1'b1);
        rnd_send(1'b1);
        rst_n = 1'b0;
        exp_q.delete();
        n_out = 0;
        @(negedge clk);
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_zero", 64'(zero), 64'd1);
        chk("mrst_count", 64'(result_count), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bp_mode = 0;
        repeat (5) @(posedge clk);
        #1;
        send({$urandom, $urandom}, 64'd0, 3'd2, 1'b1, 1'b0, mk(64'd0));
        drain();
        chk("mrst_count_after", 64'(result_count), 64'd1);

        // 8-bit instance: flags and counter wrap
        b_in_0 = 8'hFF; b_in_1 = 8'hFF; b_sel = 3'd4; b_in_valid = 1'b1;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("w8_xor_valid", 64'(b_out_valid), 64'd1);
        chk("w8_xor_out", 64'(b_out), 64'd0);
        chk("w8_xor_zero", 64'(b_zero), 64'd1);
        chk("w8_xor_parity", 64'(b_parity), 64'd0);
        b_sel = 3'd2; b_in_valid = 1'b1;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("w8_or_out", 64'(b_out), 64'hFF);
        chk("w8_or_ones", 64'(b_ones), 64'd1);
        b_sel = 3'd4; b_in_valid = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("w8_count_wrap", 64'(b_count), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
